key_step_conditioner: RTL

KEY_STEP_CONDITIONER -- requirements
Module: key_step_conditioner

---
 rtl/key_step_conditioner.sv | 105 ++++++++++
 1 files changed

// File: rtl/key_step_conditioner.sv
// key_step_conditioner: debounced pushbutton to single-cycle up/down step strobes with auto-repeat
module key_step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        CLOCK_50,
  input  logic [1:0]  KEY,
  input  logic [17:0] SW,
  output logic        STEP_UP,
  output logic        STEP_DN,
  output logic        CLEAR,
  output logic [1:0]  LEDG
);
  localparam int MAX_AB = DEBOUNCE_CYCLES > REPEAT_DELAY ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP = MAX_AB > REPEAT_PERIOD ? MAX_AB : REPEAT_PERIOD;
  localparam int CW = $clog2(MAXP + 2);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES > 0 ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY > 0 ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD > 0 ? REPEAT_PERIOD - 1 : 0);
  typedef enum logic [2:0] {IDLE, DEB_PRESS, HELD, REPEAT, DEB_RELEASE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [1:0] key_s, sw_m, sw_s;
  logic clr_m, press, emit;
  logic unused_sw;
  assign unused_sw = ^SW[16:2];
  assign press = key_s[1];
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  always_comb begin
    state_n = state;
    cnt_n = cnt_inc;
    emit = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (press) state_n = DEB_PRESS;
      end
      DEB_PRESS:
        if (!press) begin
          state_n = IDLE;
          cnt_n = '0;
        end else if (cnt >= DEB_LAST) begin
          state_n = HELD;
          cnt_n = '0;
          emit = 1'b1;
        end
      HELD:
        // the cycle that first sees the release already counts toward the release debounce
        if (!press) begin
          state_n = DEB_RELEASE;
          cnt_n = CW'(1);
        end else if (REPEAT_DELAY > 0 && cnt >= DLY_LAST) begin
          state_n = REPEAT;
          cnt_n = '0;
          emit = 1'b1;
        end
      REPEAT:
        if (!press) begin
          state_n = DEB_RELEASE;
          cnt_n = CW'(1);
        end else if (cnt >= PER_LAST) begin
          cnt_n = '0;
          emit = 1'b1;
        end
      DEB_RELEASE:
        if (press) begin
          state_n = HELD;
          cnt_n = '0;
        end else if (cnt >= DEB_LAST) begin
          state_n = IDLE;
          cnt_n = '0;
        end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (!KEY[1]) begin
      key_s <= '0;
      sw_m <= '0;
      sw_s <= '0;
      clr_m <= 1'b0;
      CLEAR <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      STEP_UP <= 1'b0;
      STEP_DN <= 1'b0;
      LEDG <= '0;
    end else begin
      key_s <= {key_s[0], ~KEY[0]};
      sw_m <= SW[1:0];
      sw_s <= sw_m;
      clr_m <= SW[17];
      CLEAR <= clr_m;
      state <= state_n;
      cnt <= cnt_n;
      STEP_UP <= emit & sw_s[1] & sw_s[0] & ~CLEAR;
      STEP_DN <= emit & sw_s[1] & ~sw_s[0] & ~CLEAR;
      LEDG <= {state_n == REPEAT, state_n inside {HELD, REPEAT, DEB_RELEASE}};
    end
  end
endmodule
